scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Threshold-scan scheduler for the PMT test stand. It sweeps the DAC threshold register from a first to a last code in fixed steps, and for each code runs one counter measurement window. It then reports a (threshold, count) pair. It is a third requester on the shared 8-bit register bus, next to the VJTAG and Ethernet command paths, and drives the counter's step start/stop strobes in place of the Ethernet step exports.

## Interface
Parameters:
- SETTLE_CYCLES, 50000: cycles waited after each DAC write before measuring (1 ms at 50 MHz); must be ≥1.
- DAC_ADDR, 8'h30: register-bus address of the DAC threshold register.

Ports:
- clock50Mhz  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a scan when idle.
- abort  in  1  one-cycle pulse; cancels a running scan.
- thr_first  in  8  first threshold code.
- thr_last  in  8  last threshold code (inclusive bound).
- thr_step  in  8  code increment; 0 is treated as 1.
- window  in  32  measurement window length in cycles; 0 is treated as 1.
- bus_req  out  1  register-bus request.
- bus_gnt  in  1  register-bus grant from the command block.
- bus_addr  out  8  register address; equals DAC_ADDR while bus_write is high, 0 otherwise.
- bus_data  out  8  write data; equals the current threshold while bus_write is high, 0 otherwise.
- bus_write  out  1  one-cycle write strobe.
- step_start  out  1  one-cycle pulse; counter starts a window.
- step_stop  out  1  one-cycle pulse; counter stops a window.
- count_value  in  32  counter result, valid 2 cycles after step_stop.
- res_valid  out  1  one-cycle pulse; a result pair is on res_thr/res_count.
- res_thr  out  8  threshold of the reported point (held until the next res_valid).
- res_count  out  32  count of the reported point (held).
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when a scan completes normally.

## Operation
- thr_first, thr_last, thr_step and window are latched on an accepted start and ignored afterwards.
- FSM states: IDLE, REQ, WRITE, SETTLE, MEAS, STOP, CAPTURE, REPORT, NEXT, DONE.
  - IDLE → REQ: on start; thr ← thr_first. A start while not in IDLE is ignored.
  - REQ: bus_req = 1. Moves to WRITE in the cycle after bus_gnt is sampled high.
  - WRITE: exactly one cycle; bus_write = 1 with addr/data valid and bus_req still high. Goes to SETTLE.
  - SETTLE: stays SETTLE_CYCLES cycles, then goes to MEAS.
  - MEAS: step_start pulses in the first MEAS cycle. MEAS lasts max(window,1) cycles, then goes to STOP.
  - STOP: one cycle; step_stop = 1. Goes to CAPTURE.
  - CAPTURE: two cycles; count_value is sampled on the second cycle. Goes to REPORT.
  - REPORT: one cycle; res_valid = 1; res_thr = thr; res_count = the sampled value. Goes to NEXT.
  - NEXT: 9-bit sum s = thr + max(thr_step,1). If s > thr_last (this includes s ≥ 256), go to DONE. Otherwise thr ← s[7:0] and go to REQ.
  - DONE: one cycle; done = 1. Goes to IDLE.
- If thr_first > thr_last, exactly one point (thr_first) is measured.
- Number of points = floor((thr_last − thr_first)/step) + 1 when thr_first ≤ thr_last.
- Abort (from any non-IDLE state) takes effect on the next edge: state ← IDLE, bus_req drops, done is not pulsed, res_valid is not pulsed.
  - If aborted in MEAS, step_stop pulses once in the cycle after abort.
  - If abort coincides with the WRITE cycle, that write still completes (the strobe is already out); nothing further is issued.
- start and abort in the same IDLE cycle: abort wins, and the scan does not start.

## Timing
- Reset values: all outputs 0, res_thr = 0, res_count = 0, state IDLE. A reset mid-scan returns every output to 0 on the next edge, with no step_stop.
- start at edge N: busy = 1 and bus_req = 1 from N+1.
- bus_gnt high sampled at edge G: bus_write is high in cycle G+1; bus_req falls at G+2.
- Per point, after the write: SETTLE_CYCLES + window + 1 (STOP) + 2 (CAPTURE) + 1 (REPORT) + 1 (NEXT) cycles, plus the bus wait.
- busy falls in the cycle after DONE.

## Test plan
- SETTLE_CYCLES = 4; thr 10→30 step 10; window = 8; bus_gnt tied high.
  - Required: three writes with data 10, 20, 30 to 8'h30.
  - Required: three res_valid pulses with res_count equal to count_value driven at each capture (e.g. 100, 200, 300), followed by one done.
- thr 250→255 step 10 → one point at 250, then done (9-bit overflow handled, no wrap to 4).
- thr_first = 40 > thr_last = 20, thr_step = 0, window = 0 → one point at 40 with a 1-cycle MEAS window; done.
- Hold bus_gnt low for 100 cycles → bus_req stays high, no bus_write. After gnt rises, exactly one write occurs and bus_req falls 2 cycles after gnt is sampled.
- Abort during MEAS of the 2nd point → one step_stop, bus_req = 0, busy = 0 next cycle, no done; a new start then rescans from the new thr_first.
- Synchronous reset mid-SETTLE, and a start pulse while busy → all outputs 0 after reset; the extra start has no effect (point count and sequence unchanged).

Source files
------------

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_sequencer
//  Purpose  : Threshold-scan scheduler for the PMT test stand. Sweeps the DAC
//             threshold register from a first to a last code in fixed steps.
//             For every code it writes the DAC over the shared register bus,
//             lets the discriminator settle and runs one counter measurement
//             window. It then reports the (threshold, count) pair.
//
//  Ports    : clock50Mhz, reset       - clock, synchronous active-high reset
//             start, abort            - scan control pulses
//             thr_first/last/step     - scan range, latched on start
//             window                  - measurement window length in cycles
//             bus_req/gnt/addr/data/write - register-bus requester side
//             step_start, step_stop   - counter window strobes
//             count_value             - counter result (valid 2 cycles after stop)
//             res_valid/thr/count     - reported measurement point
//             busy, done              - scan status
//
//  Revision : 1.0 - initial release
// ============================================================================
module scan_sequencer #(
    parameter int         SETTLE_CYCLES = 50000,
    parameter logic [7:0] DAC_ADDR      = 8'h30
) (
    input  logic        clock50Mhz,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  thr_first,
    input  logic [7:0]  thr_last,
    input  logic [7:0]  thr_step,
    input  logic [31:0] window,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_data,
    output logic        bus_write,
    output logic        step_start,
    output logic        step_stop,
    input  logic [31:0] count_value,
    output logic        res_valid,
    output logic [7:0]  res_thr,
    output logic [31:0] res_count,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_REQ     = 4'd1,
        S_WRITE   = 4'd2,
        S_SETTLE  = 4'd3,
        S_MEAS    = 4'd4,
        S_STOP    = 4'd5,
        S_CAPTURE = 4'd6,
        S_REPORT  = 4'd7,
        S_NEXT    = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    // Counters are loaded with (length - 1) and run down to zero.
    localparam logic [31:0] c_settle_last = 32'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_thr;          // threshold currently being measured
    logic [7:0]  r_last;         // latched inclusive upper bound
    logic [7:0]  r_step;         // latched step, already forced to >= 1
    logic [31:0] r_window;       // latched window, already forced to >= 1
    logic [31:0] r_settle_cnt;
    logic [31:0] r_meas_cnt;
    logic        r_cap_second;   // second CAPTURE cycle flag
    logic        r_gnt_seen;     // grant sampled high while requesting

    // Nine bits so that stepping past code 255 is detected instead of wrapping.
    logic [8:0]  w_next_sum;
    assign w_next_sum = {1'b0, r_thr} + {1'b0, r_step};

    always_ff @(posedge clock50Mhz) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_thr        <= 8'd0;
            r_last       <= 8'd0;
            r_step       <= 8'd1;
            r_window     <= 32'd1;
            r_settle_cnt <= 32'd0;
            r_meas_cnt   <= 32'd0;
            r_cap_second <= 1'b0;
            r_gnt_seen   <= 1'b0;
            bus_req      <= 1'b0;
            bus_addr     <= 8'd0;
            bus_data     <= 8'd0;
            bus_write    <= 1'b0;
            step_start   <= 1'b0;
            step_stop    <= 1'b0;
            res_valid    <= 1'b0;
            res_thr      <= 8'd0;
            res_count    <= 32'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Single-cycle strobes default low; the bus address/data lines
            // are only non-zero alongside the write strobe.
            bus_write  <= 1'b0;
            bus_addr   <= 8'd0;
            bus_data   <= 8'd0;
            step_start <= 1'b0;
            step_stop  <= 1'b0;
            res_valid  <= 1'b0;
            done       <= 1'b0;

            if (abort && (r_state != S_IDLE)) begin
                // A write already on the bus completes by itself; an open
                // counter window must be closed so the counter is not left
                // running.
                r_state    <= S_IDLE;
                bus_req    <= 1'b0;
                busy       <= 1'b0;
                r_gnt_seen <= 1'b0;
                step_stop  <= (r_state == S_MEAS);
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_thr      <= thr_first;
                            r_last     <= thr_last;
                            r_step     <= (thr_step == 8'd0) ? 8'd1 : thr_step;
                            r_window   <= (window == 32'd0) ? 32'd1 : window;
                            r_gnt_seen <= 1'b0;
                            r_state    <= S_REQ;
                            bus_req    <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end

                    S_REQ: begin
                        // The grant is registered first, so the write goes
                        // out in the cycle after the grant was sampled.
                        if (r_gnt_seen) begin
                            r_gnt_seen <= 1'b0;
                            r_state    <= S_WRITE;
                            bus_write  <= 1'b1;
                            bus_addr   <= DAC_ADDR;
                            bus_data   <= r_thr;
                        end else begin
                            r_gnt_seen <= bus_gnt;
                        end
                    end

                    S_WRITE: begin
                        bus_req      <= 1'b0;
                        r_settle_cnt <= c_settle_last;
                        r_state      <= S_SETTLE;
                    end

                    S_SETTLE: begin
                        if (r_settle_cnt == 32'd0) begin
                            r_meas_cnt <= r_window - 32'd1;
                            step_start <= 1'b1;
                            r_state    <= S_MEAS;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 32'd1;
                        end
                    end

                    S_MEAS: begin
                        if (r_meas_cnt == 32'd0) begin
                            step_stop <= 1'b1;
                            r_state   <= S_STOP;
                        end else begin
                            r_meas_cnt <= r_meas_cnt - 32'd1;
                        end
                    end

                    S_STOP: begin
                        r_cap_second <= 1'b0;
                        r_state      <= S_CAPTURE;
                    end

                    S_CAPTURE: begin
                        // The counter result becomes valid two cycles after
                        // the stop strobe, i.e. in the second CAPTURE cycle.
                        if (r_cap_second) begin
                            r_cap_second <= 1'b0;
                            res_valid    <= 1'b1;
                            res_thr      <= r_thr;
                            res_count    <= count_value;
                            r_state      <= S_REPORT;
                        end else begin
                            r_cap_second <= 1'b1;
                        end
                    end

                    S_REPORT: begin
                        r_state <= S_NEXT;
                    end

                    S_NEXT: begin
                        if (w_next_sum > {1'b0, r_last}) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_thr   <= w_next_sum[7:0];
                            bus_req <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end

                    S_DONE: begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_sequencer
//  Purpose  : Self-checking bench for scan_sequencer. Expected point lists
//             come from the scan rules (first, first+step, ... <= last);
//             expected counts come from a per-threshold random table that
//             the bench's counter model presents only in the valid cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scan_sequencer;

    localparam int         S  = 4;
    localparam logic [7:0] DA = 8'h30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  thr_first = 8'd0;
    logic [7:0]  thr_last = 8'd0;
    logic [7:0]  thr_step = 8'd0;
    logic [31:0] window = 32'd0;
    logic        bus_gnt = 1'b0;
    logic [31:0] count_value = 32'd0;
    logic        bus_req, bus_write, step_start, step_stop, res_valid, busy, done;
    logic [7:0]  bus_addr, bus_data, res_thr;
    logic [31:0] res_count;

    scan_sequencer #(.SETTLE_CYCLES(S), .DAC_ADDR(DA)) dut (
        .clock50Mhz(clk), .reset(reset), .start(start), .abort(abort),
        .thr_first(thr_first), .thr_last(thr_last), .thr_step(thr_step),
        .window(window), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_write(bus_write),
        .step_start(step_start), .step_stop(step_stop),
        .count_value(count_value), .res_valid(res_valid), .res_thr(res_thr),
        .res_count(res_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  a;
        logic [31:0] v;
    } ev_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    ev_t         wr_q[$];
    ev_t         res_q[$];
    int          done_q[$];
    int          sst_q[$];
    int          ssp_q[$];
    int          fall_q[$];
    int          exp_q[$];
    int          bad_bus = 0;
    int          stop_at = -10;
    logic [7:0]  cur_thr = 8'd0;
    logic        prev_req = 1'b0;
    logic [31:0] cv [256];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus counter model: the count for the last written threshold
    // is only presented in the cycle two after step_stop, garbage otherwise.
    always @(negedge clk) begin
        ev_t e;
        count_value = (cyc == stop_at + 2) ? cv[cur_thr] : $urandom;
        if (step_stop === 1'b1) begin
            stop_at = cyc;
            ssp_q.push_back(cyc);
        end
        if (step_start === 1'b1) sst_q.push_back(cyc);
        if (bus_write === 1'b1) begin
            e.cyc = cyc; e.a = bus_addr; e.v = {24'd0, bus_data};
            wr_q.push_back(e);
            cur_thr = bus_data;
            if (bus_req !== 1'b1) bad_bus++;
        end else if (bus_addr !== 8'd0 || bus_data !== 8'd0) begin
            bad_bus++;
        end
        if (res_valid === 1'b1) begin
            e.cyc = cyc; e.a = res_thr; e.v = res_count;
            res_q.push_back(e);
        end
        if (done === 1'b1) done_q.push_back(cyc);
        if (prev_req === 1'b1 && bus_req === 1'b0) fall_q.push_back(cyc);
        prev_req = bus_req;
    end

    task automatic clear_logs();
        wr_q.delete(); res_q.delete(); done_q.delete();
        sst_q.delete(); ssp_q.delete(); fall_q.delete();
        bad_bus = 0;
    endtask

    // Runs one complete scan and checks it against the scan rules.
    // gnt_mode: 0 grant tied high, 1 random grant, 2 grant low for 100 cycles.
    task automatic run_scan(input logic [7:0] f, input logic [7:0] l,
                            input logic [7:0] s, input logic [31:0] w,
                            input int gnt_mode, input int extra_start);
        int n, rise, exit_cyc, st, we, t, nform, lapses;
        clear_logs();
        st = (s == 8'd0) ? 1 : int'(s);
        we = (w == 32'd0) ? 1 : int'(w);
        exp_q.delete();
        t = int'(f);
        exp_q.push_back(t);
        while (t + st <= int'(l)) begin
            t = t + st;
            exp_q.push_back(t);
        end
        nform = (f <= l) ? ((int'(l) - int'(f)) / st + 1) : 1;

        @(negedge clk);
        thr_first = f; thr_last = l; thr_step = s; window = w; start = 1'b1;
        bus_gnt = (gnt_mode == 0);
        @(negedge clk);
        start = 1'b0;
        thr_first = 8'($urandom); thr_last = 8'($urandom);
        thr_step = 8'($urandom); window = 32'($urandom_range(0, 3));
        n = 0; rise = -1; lapses = 0;
        while (busy === 1'b1 && n < 20000) begin
            if (gnt_mode == 1) bus_gnt = ($urandom_range(0, 1) == 1);
            else if (gnt_mode == 2) begin
                if (n < 100) begin
                    bus_gnt = 1'b0;
                    if (bus_req !== 1'b1) lapses++;
                end else begin
                    if (rise < 0) rise = cyc;
                    bus_gnt = 1'b1;
                end
            end else bus_gnt = 1'b1;
            start = (extra_start > 0 && n == extra_start);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        exit_cyc = cyc;
        @(negedge clk);

        checks++;
        if (n >= 20000) begin
            failures++; $display("FAIL scan_timeout f=%0d l=%0d got busy still high", f, l);
        end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL write_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
        end
        checks++;
        if (res_q.size() != nform) begin
            failures++; $display("FAIL result_count got=%0d exp=%0d", res_q.size(), nform);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= wr_q.size() || i >= res_q.size() || i >= sst_q.size() || i >= ssp_q.size()) break;
            checks++;
            if (wr_q[i].a !== DA || wr_q[i].v !== 32'(exp_q[i])) begin
                failures++; $display("FAIL write_%0d got addr=%h data=%0d exp addr=%h data=%0d",
                                     i, wr_q[i].a, wr_q[i].v, DA, exp_q[i]);
            end
            checks++;
            if (res_q[i].a !== 8'(exp_q[i]) || res_q[i].v !== cv[exp_q[i]]) begin
                failures++; $display("FAIL result_%0d got thr=%0d count=%h exp thr=%0d count=%h",
                                     i, res_q[i].a, res_q[i].v, exp_q[i], cv[exp_q[i]]);
            end
            checks++;
            if (sst_q[i] != wr_q[i].cyc + S + 1 || ssp_q[i] != wr_q[i].cyc + S + we + 1 ||
                res_q[i].cyc != wr_q[i].cyc + S + we + 4) begin
                failures++; $display("FAIL timing_%0d got start=%0d stop=%0d res=%0d exp %0d %0d %0d",
                                     i, sst_q[i], ssp_q[i], res_q[i].cyc, wr_q[i].cyc + S + 1,
                                     wr_q[i].cyc + S + we + 1, wr_q[i].cyc + S + we + 4);
            end
        end
        checks++;
        if (done_q.size() != 1) begin
            failures++; $display("FAIL done_count got=%0d exp=1", done_q.size());
        end else if (res_q.size() > 0) begin
            checks++;
            if (done_q[0] != res_q[res_q.size()-1].cyc + 2 || exit_cyc != done_q[0] + 1) begin
                failures++; $display("FAIL done_timing got done=%0d busy_low=%0d exp %0d %0d",
                                     done_q[0], exit_cyc, res_q[res_q.size()-1].cyc + 2,
                                     res_q[res_q.size()-1].cyc + 3);
            end
        end
        checks++;
        if (res_thr !== 8'(exp_q[exp_q.size()-1]) || res_count !== cv[exp_q[exp_q.size()-1]]) begin
            failures++; $display("FAIL result_hold got thr=%0d count=%h exp thr=%0d",
                                 res_thr, res_count, exp_q[exp_q.size()-1]);
        end
        checks++;
        if (bad_bus != 0) begin
            failures++; $display("FAIL bus_idle_values got=%0d bad cycles exp=0", bad_bus);
        end
        if (gnt_mode == 2) begin
            checks++;
            if (lapses != 0) begin
                failures++; $display("FAIL req_held got=%0d low cycles exp=0", lapses);
            end
            checks++;
            if (wr_q.size() == 0 || wr_q[0].cyc != rise + 2 ||
                fall_q.size() == 0 || fall_q[0] != rise + 3) begin
                failures++; $display("FAIL gnt_timing got write=%0d fall=%0d exp %0d %0d",
                                     (wr_q.size() > 0) ? wr_q[0].cyc : -1,
                                     (fall_q.size() > 0) ? fall_q[0] : -1, rise + 2, rise + 3);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_req, bus_addr, bus_data, bus_write, step_start, step_stop, res_valid,
             res_thr, res_count, busy, done} !== '0) begin
            failures++; $display("FAIL reset_outputs got nonzero outputs exp all zero");
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_req, busy, bus_write, done} !== 4'b0) begin
            failures++; $display("FAIL idle_after_reset got req=%b busy=%b exp 0", bus_req, busy);
        end
    endtask

    task automatic test_basic();      run_scan(8'd10, 8'd30, 8'd10, 32'd8, 0, 0);   endtask
    task automatic test_overflow();   run_scan(8'd250, 8'd255, 8'd10, 32'd8, 0, 0); endtask
    task automatic test_reverse();    run_scan(8'd40, 8'd20, 8'd0, 32'd0, 0, 0);    endtask
    task automatic test_gnt_wait();   run_scan(8'd77, 8'd77, 8'd1, 32'd3, 2, 0);    endtask
    task automatic test_start_while_busy(); run_scan(8'd5, 8'd25, 8'd5, 32'd6, 0, 7); endtask

    task automatic test_abort();
        int n, a, after;
        clear_logs();
        @(negedge clk);
        thr_first = 8'd10; thr_last = 8'd60; thr_step = 8'd10; window = 32'd20;
        bus_gnt = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (sst_q.size() < 2 && n < 2000) begin
            @(negedge clk); n++;
        end
        repeat (3) @(negedge clk);
        abort = 1'b1; a = cyc;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (step_stop !== 1'b1 || bus_req !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_outputs got stop=%b req=%b busy=%b exp 1 0 0",
                                 step_stop, bus_req, busy);
        end
        repeat (12) @(negedge clk);
        after = 0;
        foreach (ssp_q[i]) if (ssp_q[i] > a) after++;
        checks++;
        if (after != 1 || ssp_q[ssp_q.size()-1] != a + 1) begin
            failures++; $display("FAIL abort_stop got=%0d pulses exp=1 at %0d", after, a + 1);
        end
        checks++;
        if (done_q.size() != 0 || res_q.size() != 1 || wr_q.size() != 2) begin
            failures++; $display("FAIL abort_effects got done=%0d res=%0d wr=%0d exp 0 1 2",
                                 done_q.size(), res_q.size(), wr_q.size());
        end
        run_scan(8'd33, 8'd45, 8'd4, 32'd5, 0, 0);
    endtask

    task automatic test_start_abort_idle();
        clear_logs();
        @(negedge clk);
        thr_first = 8'd1; thr_last = 8'd2; thr_step = 8'd1; window = 32'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0 || wr_q.size() != 0) begin
            failures++; $display("FAIL start_abort got busy=%b req=%b writes=%0d exp 0 0 0",
                                 busy, bus_req, wr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        @(negedge clk);
        thr_first = 8'd5; thr_last = 8'd25; thr_step = 8'd5; window = 32'd6;
        bus_gnt = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (wr_q.size() < 1 && n < 2000) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus_req, bus_addr, bus_data, bus_write, step_start, step_stop, res_valid,
             res_thr, res_count, busy, done} !== '0) begin
            failures++; $display("FAIL reset_mid_outputs got busy=%b req=%b exp all zero", busy, bus_req);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (wr_q.size() != 1 || ssp_q.size() != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_quiet got wr=%0d stops=%0d busy=%b exp 1 0 0",
                                 wr_q.size(), ssp_q.size(), busy);
        end
        run_scan(8'd5, 8'd25, 8'd5, 32'd6, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] f, l;
        repeat (6) begin
            f = 8'($urandom_range(0, 195));
            l = 8'(int'(f) + int'($urandom_range(0, 60)));
            if ($urandom_range(0, 3) == 0) l = 8'($urandom_range(0, 255));
            run_scan(f, l, 8'($urandom_range(0, 20)), 32'($urandom_range(0, 12)), 1, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) cv[i] = $urandom;
        test_reset();
        test_basic();
        test_overflow();
        test_reverse();
        test_gnt_wait();
        test_abort();
        test_start_abort_idle();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
